// File: rtl/pattern_generator_pkg.sv
// pattern_pkg: shared types and elaboration-time helpers for the 480p
// test-pattern source.
//   pattern_mode_t : the four selectable render modes (encoding = i_mode value)
//   DIR_POS/DIR_NEG: bouncing-square direction encoding
//   full()         : all-ones colour value for a given channel width
//   bg_blue()      : background blue (8'h8B scaled to the channel width)
//   bar_threshold(): left edge of colour bar k for a given active width
package pattern_pkg;

  typedef enum logic [1:0] {
    PM_SQUARE  = 2'd0,
    PM_BARS    = 2'd1,
    PM_CHECKER = 2'd2,
    PM_BOUNCE  = 2'd3
  } pattern_mode_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  // Widest legal channel; the colour helpers return this width and callers
  // keep the low COLOUR_BITS bits.
  localparam int MAX_COLOUR_BITS = 12;

  function automatic logic [11:0] full(input int bits);
    return 12'hFFF >> (MAX_COLOUR_BITS - bits);
  endfunction

  function automatic logic [11:0] bg_blue(input int bits);
    return 12'h08B << (bits - 8);
  endfunction

  // Evaluated with constant arguments only, so no divider is built.
  function automatic int bar_threshold(input int k, input int h_res);
    return (k * h_res) / 8;
  endfunction

endpackage

// File: rtl/pattern_generator_bounce_tracker.sv
// bounce_tracker: position and direction of the animated square.
// Moves SPEED pixels per axis on every new-frame pulse unless frozen; the
// square is kept fully inside the active area, clamping to the edge and
// reversing direction in the same update when it would touch or cross it.
//   i_clk    : pixel clock
//   i_rst    : synchronous active-high reset (returns square to centre, dirs +)
//   i_nf     : one-cycle new-frame pulse
//   i_freeze : holds the position while high
//   o_pos_x  : left edge of the square
//   o_pos_y  : top edge of the square
module bounce_tracker
  import pattern_pkg::*;
#(
  parameter int COORD_BITS = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SQ_SIZE    = 200,
  parameter int SPEED      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_nf,
  input  logic                  i_freeze,
  output logic [COORD_BITS-1:0] o_pos_x,
  output logic [COORD_BITS-1:0] o_pos_y
);

  // One extra bit so pos+SQ_SIZE+SPEED cannot wrap.
  localparam int W = COORD_BITS + 1;

  localparam logic [W-1:0]          SQ_W    = W'(SQ_SIZE);
  localparam logic [W-1:0]          SPD_W   = W'(SPEED);
  localparam logic [W-1:0]          H_W     = W'(H_RES);
  localparam logic [W-1:0]          V_W     = W'(V_RES);
  localparam logic [COORD_BITS-1:0] SPD_C   = COORD_BITS'(SPEED);
  localparam logic [COORD_BITS-1:0] X_MAX   = COORD_BITS'(H_RES - SQ_SIZE);
  localparam logic [COORD_BITS-1:0] Y_MAX   = COORD_BITS'(V_RES - SQ_SIZE);
  localparam logic [COORD_BITS-1:0] X_START = COORD_BITS'((H_RES - SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] Y_START = COORD_BITS'((V_RES - SQ_SIZE) / 2);

  logic [COORD_BITS-1:0] pos_x;
  logic [COORD_BITS-1:0] pos_y;
  logic                  dir_x;
  logic                  dir_y;

  // One axis update; returns {new_dir, new_pos}. In the non-clamping
  // forward branch pos+SPEED is below res, so the narrow add cannot wrap.
  function automatic logic [COORD_BITS:0] step(
    input logic [COORD_BITS-1:0] pos,
    input logic                  dir,
    input logic [W-1:0]          res,
    input logic [COORD_BITS-1:0] max_pos
  );
    logic [W-1:0] far_edge;
    far_edge = {1'b0, pos} + SQ_W + SPD_W;
    if (dir == DIR_POS) begin
      if (far_edge >= res) step = {DIR_NEG, max_pos};
      else                 step = {DIR_POS, pos + SPD_C};
    end else begin
      if (pos <= SPD_C)    step = {DIR_POS, {COORD_BITS{1'b0}}};
      else                 step = {DIR_NEG, pos - SPD_C};
    end
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pos_x <= X_START;
      pos_y <= Y_START;
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
    end else if (i_nf && !i_freeze) begin
      {dir_x, pos_x} <= step(pos_x, dir_x, H_W, X_MAX);
      {dir_y, pos_y} <= step(pos_y, dir_y, V_W, Y_MAX);
    end
  end

  assign o_pos_x = pos_x;
  assign o_pos_y = pos_y;

endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: multi-mode test-pattern source for the 480p HDMI path.
// Two-stage pipeline: stage 1 registers a per-pixel colour classification
// plus the timing strobes, stage 2 turns the classification into colours.
// RGB, hsync, vsync and de all leave exactly 2 cycles after they enter.
// There is no handshake: every clock carries one pixel, and the strobes
// (i_hsync/i_vsync/i_de/i_nf) are sampled as level values on each edge.
//   i_clk, i_rst       : pixel clock, synchronous active-high reset
//   i_sx, i_sy         : current pixel coordinate
//   i_hsync/i_vsync/i_de: timing strobes, forwarded as o_* delayed 2 cycles
//   i_nf               : new-frame pulse; latches i_mode, advances the square
//   i_mode             : requested pattern (pattern_mode_t encoding)
//   i_freeze           : holds the bouncing-square position
//   o_r, o_g, o_b      : registered colour, 0 during blanking
//   o_mode             : mode currently being rendered
module pattern_generator
  import pattern_pkg::*;
#(
  parameter int COORD_BITS  = 10,
  parameter int COLOUR_BITS = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SQ_SIZE     = 200,
  parameter int SPEED       = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [COORD_BITS-1:0]  i_sx,
  input  logic [COORD_BITS-1:0]  i_sy,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_de,
  input  logic                   i_nf,
  input  logic [1:0]             i_mode,
  input  logic                   i_freeze,
  output logic [COLOUR_BITS-1:0] o_r,
  output logic [COLOUR_BITS-1:0] o_g,
  output logic [COLOUR_BITS-1:0] o_b,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de,
  output logic [1:0]             o_mode
);

  localparam int W = COORD_BITS + 1;

  localparam logic [11:0]            FULL12 = full(COLOUR_BITS);
  localparam logic [11:0]            BG12   = bg_blue(COLOUR_BITS);
  localparam logic [COLOUR_BITS-1:0] FULL_C = FULL12[COLOUR_BITS-1:0];
  localparam logic [COLOUR_BITS-1:0] BG_C   = BG12[COLOUR_BITS-1:0];

  localparam logic [COORD_BITS-1:0] SQ_X0 = COORD_BITS'((H_RES - SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] SQ_X1 = COORD_BITS'((H_RES + SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] SQ_Y0 = COORD_BITS'((V_RES - SQ_SIZE) / 2);
  localparam logic [COORD_BITS-1:0] SQ_Y1 = COORD_BITS'((V_RES + SQ_SIZE) / 2);
  localparam logic [W-1:0]          SQ_W  = W'(SQ_SIZE);

  pattern_mode_t         r_mode;
  logic [COORD_BITS-1:0] pos_x;
  logic [COORD_BITS-1:0] pos_y;

  bounce_tracker #(
    .COORD_BITS (COORD_BITS),
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .SQ_SIZE    (SQ_SIZE),
    .SPEED      (SPEED)
  ) u_bounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_nf     (i_nf),
    .i_freeze (i_freeze),
    .o_pos_x  (pos_x),
    .o_pos_y  (pos_y)
  );

  // Mode only changes on the frame boundary so a frame is never torn.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_mode <= PM_SQUARE;
    else if (i_nf) r_mode <= pattern_mode_t'(i_mode);
  end

  assign o_mode = r_mode;

  // Classification: cls_rgb selects FULL per channel; cls_bg replaces a
  // zero blue channel with the background blue (square modes only).
  logic       in_static;
  logic       in_bounce;
  logic       chk_bit;
  logic [2:0] bar_k;
  logic [2:0] cls_rgb;
  logic       cls_bg;

  always_comb begin
    in_static = (i_sx >= SQ_X0) && (i_sx < SQ_X1) &&
                (i_sy >= SQ_Y0) && (i_sy < SQ_Y1);

    in_bounce = (i_sx >= pos_x) && ({1'b0, i_sx} < ({1'b0, pos_x} + SQ_W)) &&
                (i_sy >= pos_y) && ({1'b0, i_sy} < ({1'b0, pos_y} + SQ_W));

    chk_bit = i_sx[CHECK_SHIFT] ^ i_sy[CHECK_SHIFT];

    // Largest k whose left edge is at or left of sx; edges are constants.
    bar_k = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (i_sx >= COORD_BITS'(bar_threshold(k, H_RES))) bar_k = 3'(k);
    end

    cls_rgb = 3'b000;
    cls_bg  = 1'b0;
    case (r_mode)
      PM_SQUARE: begin
        cls_rgb = {3{in_static}};
        cls_bg  = ~in_static;
      end
      PM_BARS: begin
        cls_rgb = {~bar_k[1], ~bar_k[2], ~bar_k[0]};
      end
      PM_CHECKER: begin
        cls_rgb = {3{~chk_bit}};
      end
      PM_BOUNCE: begin
        cls_rgb = {3{in_bounce}};
        cls_bg  = ~in_bounce;
      end
      default: begin
        cls_rgb = 3'b000;
        cls_bg  = 1'b0;
      end
    endcase
  end

  // Stage 1: classification and strobes.
  logic       s1_hsync;
  logic       s1_vsync;
  logic       s1_de;
  logic [2:0] s1_rgb;
  logic       s1_bg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_de    <= 1'b0;
      s1_rgb   <= 3'b000;
      s1_bg    <= 1'b0;
    end else begin
      s1_hsync <= i_hsync;
      s1_vsync <= i_vsync;
      s1_de    <= i_de;
      s1_rgb   <= cls_rgb;
      s1_bg    <= cls_bg;
    end
  end

  // Stage 2: colours, forced to 0 whenever the delayed de is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_hsync <= s1_hsync;
      o_vsync <= s1_vsync;
      o_de    <= s1_de;
      if (!s1_de) begin
        o_r <= '0;
        o_g <= '0;
        o_b <= '0;
      end else begin
        o_r <= s1_rgb[2] ? FULL_C : '0;
        o_g <= s1_rgb[1] ? FULL_C : '0;
        o_b <= s1_rgb[0] ? FULL_C : (s1_bg ? BG_C : '0);
      end
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Testbench for pattern_generator (default parameters: 640x480, 8-bit colour,
// 200-pixel square, speed 2, 32-pixel checker cells).
module tb_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       nf;
  logic [1:0] mode;
  logic       freeze;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_de;
  logic [1:0] o_mode;

  always #5 clk = ~clk;

  pattern_generator dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sx     (sx),
    .i_sy     (sy),
    .i_hsync  (hsync),
    .i_vsync  (vsync),
    .i_de     (de),
    .i_nf     (nf),
    .i_mode   (mode),
    .i_freeze (freeze),
    .o_r      (r),
    .o_g      (g),
    .o_b      (b),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de),
    .o_mode   (o_mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          sx;
    int          sy;
    logic        de;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];
  logic [2:0] exp_q[$];

  function automatic void add_vec(input logic [1:0] m, input int x, input int y,
                                  input logic d, input logic [23:0] c);
    vec_t v;
    v.mode = m; v.sx = x; v.sy = y; v.de = d; v.rgb = c;
    vecs.push_back(v);
  endfunction

  task automatic drive_idle();
    sx = '0; sy = '0; hsync = 1'b0; vsync = 1'b0; de = 1'b0; nf = 1'b0;
  endtask

  // Drive one pixel, follow it with blanking, sample 2 edges later.
  task automatic apply_pixel(input int x, input int y, input logic d);
    @(negedge clk);
    sx = 10'(x); sy = 10'(y); de = d; hsync = 1'b0; vsync = 1'b0; nf = 1'b0;
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m; nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
  endtask

  task automatic frame_pulse(input logic f);
    @(negedge clk);
    nf = 1'b1; freeze = f;
    @(negedge clk);
    nf = 1'b0;
  endtask

  logic [1:0] cur_mode;
  int ex;
  int ey;

  initial begin
    rst = 1'b1; mode = 2'd0; freeze = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_rgb", {8'h0, r, g, b}, 32'h0);
    check("rst_strobes", {29'h0, o_hsync, o_vsync, o_de}, 32'h0);
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_pos_x", 32'(dut.u_bounce.pos_x), 32'd220);
    check("rst_pos_y", 32'(dut.u_bounce.pos_y), 32'd140);
    check("rst_dirs", {30'h0, dut.u_bounce.dir_x, dut.u_bounce.dir_y}, 32'h3);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0: static square [220,420) x [140,340)
    add_vec(2'd0, 320, 240, 1'b1, 24'hFFFFFF);
    add_vec(2'd0, 220, 240, 1'b1, 24'hFFFFFF);
    add_vec(2'd0, 219, 240, 1'b1, 24'h00008B);
    add_vec(2'd0, 420, 240, 1'b1, 24'h00008B);
    add_vec(2'd0, 419, 339, 1'b1, 24'hFFFFFF);
    add_vec(2'd0, 320, 340, 1'b1, 24'h00008B);
    add_vec(2'd0, 320, 139, 1'b1, 24'h00008B);
    add_vec(2'd0, 320, 240, 1'b0, 24'h000000);
    // Mode 1: colour bars, 80 pixels wide
    add_vec(2'd1,   0,   0, 1'b1, 24'hFFFFFF);
    add_vec(2'd1,  79,   0, 1'b1, 24'hFFFFFF);
    add_vec(2'd1,  80,   0, 1'b1, 24'hFFFF00);
    add_vec(2'd1, 160,   0, 1'b1, 24'h00FFFF);
    add_vec(2'd1, 240,   0, 1'b1, 24'h00FF00);
    add_vec(2'd1, 320,   0, 1'b1, 24'hFF00FF);
    add_vec(2'd1, 400,   0, 1'b1, 24'hFF0000);
    add_vec(2'd1, 480,   0, 1'b1, 24'h0000FF);
    add_vec(2'd1, 559,   0, 1'b1, 24'h0000FF);
    add_vec(2'd1, 560,   0, 1'b1, 24'h000000);
    add_vec(2'd1, 639,   0, 1'b1, 24'h000000);
    add_vec(2'd1, 100,   5, 1'b0, 24'h000000);
    // Mode 2: checkerboard, 32-pixel cells
    add_vec(2'd2,   0,   0, 1'b1, 24'hFFFFFF);
    add_vec(2'd2,  31,   0, 1'b1, 24'hFFFFFF);
    add_vec(2'd2,  32,   0, 1'b1, 24'h000000);
    add_vec(2'd2,   0,  32, 1'b1, 24'h000000);
    add_vec(2'd2,  32,  32, 1'b1, 24'hFFFFFF);
    add_vec(2'd2,  64,   0, 1'b1, 24'hFFFFFF);
    // Mode 3: square at reset position (220,140), frozen
    add_vec(2'd3, 220, 140, 1'b1, 24'hFFFFFF);
    add_vec(2'd3, 219, 140, 1'b1, 24'h00008B);
    add_vec(2'd3, 419, 339, 1'b1, 24'hFFFFFF);
    add_vec(2'd3, 420, 339, 1'b1, 24'h00008B);
    add_vec(2'd3, 220, 340, 1'b1, 24'h00008B);

    cur_mode = 2'd0;
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur_mode) begin
        set_mode(vecs[i].mode);
        cur_mode = vecs[i].mode;
      end
      apply_pixel(vecs[i].sx, vecs[i].sy, vecs[i].de);
      check($sformatf("vec%0d_rgb", i), {8'h0, r, g, b}, {8'h0, vecs[i].rgb});
      check($sformatf("vec%0d_mode", i), 32'(o_mode), 32'(vecs[i].mode));
    end

    // Strobe alignment: outputs are the inputs delayed by exactly 2 edges.
    exp_q.delete();
    exp_q.push_back(3'b000);
    for (int i = 0; i < 24; i++) begin
      logic [2:0] s;
      s = 3'((i * 5) ^ (i >> 1));
      @(negedge clk);
      hsync = s[2]; vsync = s[1]; de = s[0];
      exp_q.push_back(s);
      @(posedge clk);
      #1;
      check($sformatf("strobe%0d", i), {29'h0, o_hsync, o_vsync, o_de}, {29'h0, exp_q.pop_front()});
    end
    drive_idle();

    // Mode change mid-frame: only i_nf makes it visible.
    set_mode(2'd0);
    mode = 2'd2;
    apply_pixel(32, 0, 1'b1);
    check("midframe_rgb_still0", {8'h0, r, g, b}, 32'h00008B);
    check("midframe_mode_still0", 32'(o_mode), 32'd0);
    @(negedge clk);
    sx = 10'd32; sy = 10'd0; de = 1'b1; nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
    @(posedge clk);
    #1;
    check("nf_pixel_old_mode", {8'h0, r, g, b}, 32'h00008B);
    check("nf_mode_now2", 32'(o_mode), 32'd2);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("after_nf_pixel_mode2", {8'h0, r, g, b}, 32'h000000);

    // Bouncing square over 200 frames from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode = 2'd3;
    for (int n = 1; n <= 200; n++) begin
      frame_pulse(1'b0);
      ex = (n < 110) ? 220 + 2 * n : 440 - 2 * (n - 110);
      ey = (n < 70)  ? 140 + 2 * n : 280 - 2 * (n - 70);
      check($sformatf("bounce%0d_x", n), 32'(dut.u_bounce.pos_x), 32'(ex));
      check($sformatf("bounce%0d_y", n), 32'(dut.u_bounce.pos_y), 32'(ey));
      if (n == 109 || n == 110 || n == 69 || n == 70) begin
        check($sformatf("bounce%0d_dirs", n),
              {30'h0, dut.u_bounce.dir_x, dut.u_bounce.dir_y},
              {30'h0, (n < 110) ? 1'b1 : 1'b0, (n < 70) ? 1'b1 : 1'b0});
      end
    end
    check("bounce_mode", 32'(o_mode), 32'd3);

    // Square at (260,20): edges of the moved square.
    apply_pixel(260, 20, 1'b1);
    check("bounce_px_tl", {8'h0, r, g, b}, 32'hFFFFFF);
    apply_pixel(259, 20, 1'b1);
    check("bounce_px_left", {8'h0, r, g, b}, 32'h00008B);
    apply_pixel(459, 219, 1'b1);
    check("bounce_px_br", {8'h0, r, g, b}, 32'hFFFFFF);
    apply_pixel(460, 219, 1'b1);
    check("bounce_px_right", {8'h0, r, g, b}, 32'h00008B);

    // Freeze holds position for 3 frames.
    repeat (3) frame_pulse(1'b1);
    check("freeze_x", 32'(dut.u_bounce.pos_x), 32'd260);
    check("freeze_y", 32'(dut.u_bounce.pos_y), 32'd20);
    freeze = 1'b0;

    // Reset mid-line in mode 3, with a coincident i_nf (reset wins).
    @(negedge clk);
    sx = 10'd320; sy = 10'd240; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; nf = 1'b1; mode = 2'd3;
    @(posedge clk);
    #1;
    check("midrst_pos_x", 32'(dut.u_bounce.pos_x), 32'd220);
    check("midrst_pos_y", 32'(dut.u_bounce.pos_y), 32'd140);
    check("midrst_mode", 32'(o_mode), 32'd0);
    check("midrst_rgb", {8'h0, r, g, b}, 32'h0);
    check("midrst_strobes", {29'h0, o_hsync, o_vsync, o_de}, 32'h0);
    @(negedge clk);
    rst = 1'b0; nf = 1'b0;
    @(posedge clk);
    #1;
    check("release1_rgb", {8'h0, r, g, b}, 32'h0);
    check("release1_strobes", {29'h0, o_hsync, o_vsync, o_de}, 32'h0);
    @(posedge clk);
    #1;
    check("release2_rgb", {8'h0, r, g, b}, 32'hFFFFFF);
    check("release2_strobes", {29'h0, o_hsync, o_vsync, o_de}, 32'h7);
    check("release2_mode", 32'(o_mode), 32'd0);
    @(negedge clk);
    drive_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
